ve_lfsr: RTL and testbench
==========================

VE_LFSR -- requirements
Module: ve_lfsr

Interface
REQ-001 Parameter LFSR_WIDTH, default 31: state width, legal range 2..256.
REQ-002 Parameter LFSR_POLY, default 31'h10000001: feedback polynomial, implicit x^W term omitted, bit k = coefficient of x^k.
REQ-003 Parameter LFSR_CONFIG, default "FIBONACCI": "FIBONACCI" or "GALOIS"; any other value is an elaboration error.
REQ-004 Parameter LFSR_FEED_FORWARD, default 0: 0 = LFSR/CRC/scrambler mode; 1 = self-synchronizing descrambler mode.
REQ-005 Parameter REVERSE, default 0: 1 = bit-reflected state and data, LSB-first processing.
REQ-006 Parameter DATA_WIDTH, default 8: bits consumed per evaluation, range 1..256.
REQ-007 Parameter STYLE, default "AUTO": "AUTO", "LOOP" or "REDUCTION"; implementation choice only, with identical results.
REQ-008 Port clk, input, 1: single clock; one clock only.
REQ-009 Port rst_n, input, 1: asynchronous active-low reset.
REQ-010 Port data_in, input, DATA_WIDTH: data bits to absorb.
REQ-011 Port state_in, input, LFSR_WIDTH: current LFSR state.
REQ-012 Port data_out, output, DATA_WIDTH: combinational output bits.
REQ-013 Port state_out, output, LFSR_WIDTH: combinational next state.
REQ-014 Port data_out_q, output, DATA_WIDTH: data_out registered on clk.
REQ-015 Port state_out_q, output, LFSR_WIDTH: state_out registered on clk.

Function
REQ-016 state_out and data_out SHALL be purely combinational functions of state_in and data_in, with zero latency. No internal state feeds them.
REQ-017 Definitions: s = working state, W = LFSR_WIDTH. Bits are processed one per step, DATA_WIDTH steps, from data bit DATA_WIDTH-1 down to 0. Step j produces data_out bit j.
REQ-018 GALOIS, FEED_FORWARD=0, per step with input bit d:
- t = s[W-1]^d
- s = (s<<1) ^ (t ? POLY : 0)
- out = t
REQ-019 GALOIS, FEED_FORWARD=1, per step:
- f = s[W-1]
- out = f^d
- s = ((s<<1) ^ (f ? POLY : 0)) ^ d, where d is XORed into bit 0
REQ-020 FIBONACCI feedback: f = s[W-1] XOR (XOR of s[k-1] for every k in 1..W-1 with POLY[k]=1).
REQ-021 FIBONACCI, FEED_FORWARD=0, per step:
- t = f^d
- s = {s[W-2:0], t}
- out = t
REQ-022 FIBONACCI, FEED_FORWARD=1, per step:
- out = f^d
- s = {s[W-2:0], d}
REQ-023 REVERSE=1: state_in and data_in SHALL be bit-reversed before processing, and state_out and data_out bit-reversed after. The original data LSB is therefore consumed first.
REQ-024 All STYLE values SHALL produce bit-identical outputs. "AUTO" selects the XOR-reduction form (a precomputed per-output-bit mask over {state_in, data_in}).
REQ-025 On every rising clk edge with rst_n high: state_out_q <= state_out and data_out_q <= data_out.
REQ-026 Expected use: GALOIS with POLY 32'h04C11DB7, REVERSE=1, DATA_WIDTH=8 and the state fed back externally is exactly Ethernet CRC-32. The final state inverted equals the FCS.

Reset
REQ-027 While rst_n is low, state_out_q and data_out_q SHALL be 0 immediately, independent of clk.
REQ-028 Reset SHALL NOT affect the combinational outputs.
REQ-029 Deasserting rst_n mid-stream: the first clk edge after release captures the current combinational values.

Verification
REQ-030 CRC config (REQ-026), state_in=32'hFFFFFFFF, data_in=8'h00 -> state_out=32'h2DFD1072.
REQ-031 CRC config, chaining ASCII "123456789" from 32'hFFFFFFFF -> final state 32'h340BC6D9; its inversion is 32'hCBF43926.
REQ-032 Default PRBS31 (FIBONACCI, 31'h10000001, FEED_FORWARD=0), data_in=0, state_in=all ones -> sequence matches a bit-serial reference model for 1000 chained evaluations.
REQ-033 Scrambler/descrambler pair with the same POLY (FEED_FORWARD 0 then 1), random data, both seeded alike -> descrambler data_out equals the original data.
REQ-034 Each STYLE value with random stimulus (10k vectors per config) -> identical outputs across styles.
REQ-035 Reset check: assert rst_n low between clk edges -> state_out_q and data_out_q are 0 at once; after release they equal the previous cycle's combinational outputs.

Source files
------------

// File: rtl/ve_lfsr.sv
// ve_lfsr: parameterised LFSR / CRC / scrambler / self-synchronising descrambler.
//
// Absorbs DATA_WIDTH data bits per evaluation into an LFSR_WIDTH-bit state, in either
// Fibonacci or Galois form. The combinational outputs depend only on state_in and
// data_in, so the caller owns the state register (e.g. feeds state_out back for CRCs).
// A registered copy of both outputs is also provided.
//
// Ports:
//   clk          - clock for the registered copies
//   rst_n        - asynchronous active-low reset; clears only the registered copies
//   data_in      - DATA_WIDTH data bits to absorb (bit DATA_WIDTH-1 first, or bit 0 first
//                  when REVERSE=1)
//   state_in     - current LFSR state
//   data_out     - combinational output bits (scrambled/descrambled data or feedback bits)
//   state_out    - combinational next state
//   data_out_q   - data_out registered on clk
//   state_out_q  - state_out registered on clk
module ve_lfsr #(
  parameter int unsigned           LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter int unsigned           LFSR_FEED_FORWARD = 0,
  parameter int unsigned           REVERSE           = 0,
  parameter int unsigned           DATA_WIDTH        = 8,
  parameter string                 STYLE             = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out,
  output logic [DATA_WIDTH-1:0] data_out_q,
  output logic [LFSR_WIDTH-1:0] state_out_q
);

  localparam int W   = int'(LFSR_WIDTH);
  localparam int D   = int'(DATA_WIDTH);
  localparam int Tot = W + D;

  localparam bit IsGalois    = (LFSR_CONFIG == "GALOIS");
  localparam bit IsFibonacci = (LFSR_CONFIG == "FIBONACCI");
  localparam bit FeedForward = (LFSR_FEED_FORWARD != 0);
  localparam bit Reverse     = (REVERSE != 0);
  localparam bit UseLoop     = (STYLE == "LOOP");
  localparam bit StyleOk     = (STYLE == "AUTO") || (STYLE == "LOOP") || (STYLE == "REDUCTION");

  // Elaboration-time parameter checks.
  if (W < 2 || W > 256) begin : g_bad_width
    $error("ve_lfsr: LFSR_WIDTH must be in 2..256");
  end
  if (D < 1 || D > 256) begin : g_bad_data_width
    $error("ve_lfsr: DATA_WIDTH must be in 1..256");
  end
  if (!IsGalois && !IsFibonacci) begin : g_bad_config
    $error("ve_lfsr: LFSR_CONFIG must be \"FIBONACCI\" or \"GALOIS\"");
  end
  if (!StyleOk) begin : g_bad_style
    $error("ve_lfsr: STYLE must be \"AUTO\", \"LOOP\" or \"REDUCTION\"");
  end
  if (LFSR_FEED_FORWARD > 1 || REVERSE > 1) begin : g_bad_flag
    $error("ve_lfsr: LFSR_FEED_FORWARD and REVERSE must be 0 or 1");
  end

  // Bit-serial evaluation of one full update. Returns {next_state, data_out}. Used both
  // at run time (LOOP style) and at elaboration time to build the XOR masks.
  function automatic logic [Tot-1:0] lfsr_eval(input logic [W-1:0] st_i,
                                               input logic [D-1:0] dt_i);
    logic [W-1:0] s;
    logic [W-1:0] s_res;
    logic [D-1:0] din;
    logic [D-1:0] dout;
    logic [D-1:0] d_res;
    logic         fb;
    for (int i = 0; i < W; i++) s[i] = Reverse ? st_i[W-1-i] : st_i[i];
    for (int i = 0; i < D; i++) din[i] = Reverse ? dt_i[D-1-i] : dt_i[i];
    dout = '0;
    for (int j = D - 1; j >= 0; j--) begin
      fb = s[W-1];
      if (IsGalois) begin
        if (FeedForward) begin
          dout[j] = fb ^ din[j];
          s       = (s << 1) ^ (fb ? LFSR_POLY : '0);
          s[0]    = s[0] ^ din[j];
        end else begin
          dout[j] = fb ^ din[j];
          s       = (s << 1) ^ (dout[j] ? LFSR_POLY : '0);
        end
      end else begin
        // Tap k (k >= 1) reads the bit that entered k steps ago, i.e. s[k-1].
        for (int k = 1; k < W; k++) begin
          if (LFSR_POLY[k]) fb = fb ^ s[k-1];
        end
        dout[j] = fb ^ din[j];
        s       = {s[W-2:0], (FeedForward ? din[j] : dout[j])};
      end
    end
    for (int i = 0; i < W; i++) s_res[i] = Reverse ? s[W-1-i] : s[i];
    for (int i = 0; i < D; i++) d_res[i] = Reverse ? dout[D-1-i] : dout[i];
    return {s_res, d_res};
  endfunction

  // The update is linear over GF(2), so each output bit is the parity of a fixed subset
  // of {state_in, data_in}. Row i is found by probing every input bit with a unit vector.
  function automatic logic [Tot-1:0][Tot-1:0] build_mask();
    logic [Tot-1:0][Tot-1:0] m;
    logic [Tot-1:0]          unit_vec;
    logic [Tot-1:0]          col;
    m = '0;
    for (int k = 0; k < Tot; k++) begin
      unit_vec    = '0;
      unit_vec[k] = 1'b1;
      col         = lfsr_eval(unit_vec[Tot-1:D], unit_vec[D-1:0]);
      for (int i = 0; i < Tot; i++) m[i][k] = col[i];
    end
    return m;
  endfunction

  logic [Tot-1:0] result;

  if (UseLoop) begin : g_loop
    always_comb begin
      result = lfsr_eval(state_in, data_in);
    end
  end else begin : g_reduction
    localparam logic [Tot-1:0][Tot-1:0] Mask = build_mask();
    logic [Tot-1:0] in_vec;
    assign in_vec = {state_in, data_in};
    always_comb begin
      result = '0;
      for (int i = 0; i < Tot; i++) result[i] = ^(Mask[i] & in_vec);
    end
  end

  assign state_out = result[Tot-1:D];
  assign data_out  = result[D-1:0];

  // Registered copies; reset clears only these, never the combinational path.
  logic [W-1:0] state_d, state_q;
  logic [D-1:0] data_d, data_q;

  always_comb begin
    state_d = state_out;
    data_d  = data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign state_out_q = state_q;
  assign data_out_q  = data_q;

endmodule

// File: tb/tb_ve_lfsr.sv
module tb_ve_lfsr;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  localparam logic [255:0] PrbsPoly = 256'(31'h10000001);
  localparam logic [255:0] CrcPoly  = 256'(32'h04C11DB7);
  localparam logic [255:0] ScrPoly  = 256'(7'h41);
  localparam logic [255:0] GalPoly  = 256'(16'h1021);

  // Default PRBS31 configuration, AUTO and LOOP styles.
  logic [30:0] p_si, p_so, p_sq, p_so_l, p_sq_l;
  logic [7:0]  p_di, p_do, p_dq, p_do_l, p_dq_l;
  // Ethernet CRC-32 configuration in all three styles (0 AUTO, 1 LOOP, 2 REDUCTION).
  logic [31:0] c_si;
  logic [7:0]  c_di;
  logic [31:0] c_so [3];
  logic [31:0] c_sq [3];
  logic [7:0]  c_do [3];
  logic [7:0]  c_dq [3];
  // Fibonacci scrambler / descrambler pair, reflected, 5 bits per evaluation.
  logic [6:0]  s_si, s_so, s_sq, d_si, d_so, d_sq;
  logic [4:0]  s_di, s_do, s_dq, d_di, d_do, d_dq;
  // Galois descrambler.
  logic [15:0] g_si, g_so, g_sq;
  logic [3:0]  g_di, g_do, g_dq;

  ve_lfsr u_prbs (
    .clk(clk), .rst_n(rst_n), .data_in(p_di), .state_in(p_si), .data_out(p_do),
    .state_out(p_so), .data_out_q(p_dq), .state_out_q(p_sq)
  );
  ve_lfsr #(.STYLE("LOOP")) u_prbs_loop (
    .clk(clk), .rst_n(rst_n), .data_in(p_di), .state_in(p_si), .data_out(p_do_l),
    .state_out(p_so_l), .data_out_q(p_dq_l), .state_out_q(p_sq_l)
  );
  ve_lfsr #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"), .REVERSE(1),
    .DATA_WIDTH(8), .STYLE("AUTO")
  ) u_crc_auto (
    .clk(clk), .rst_n(rst_n), .data_in(c_di), .state_in(c_si), .data_out(c_do[0]),
    .state_out(c_so[0]), .data_out_q(c_dq[0]), .state_out_q(c_sq[0])
  );
  ve_lfsr #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"), .REVERSE(1),
    .DATA_WIDTH(8), .STYLE("LOOP")
  ) u_crc_loop (
    .clk(clk), .rst_n(rst_n), .data_in(c_di), .state_in(c_si), .data_out(c_do[1]),
    .state_out(c_so[1]), .data_out_q(c_dq[1]), .state_out_q(c_sq[1])
  );
  ve_lfsr #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"), .REVERSE(1),
    .DATA_WIDTH(8), .STYLE("REDUCTION")
  ) u_crc_red (
    .clk(clk), .rst_n(rst_n), .data_in(c_di), .state_in(c_si), .data_out(c_do[2]),
    .state_out(c_so[2]), .data_out_q(c_dq[2]), .state_out_q(c_sq[2])
  );
  ve_lfsr #(
    .LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"), .LFSR_FEED_FORWARD(0),
    .REVERSE(1), .DATA_WIDTH(5), .STYLE("LOOP")
  ) u_scr (
    .clk(clk), .rst_n(rst_n), .data_in(s_di), .state_in(s_si), .data_out(s_do),
    .state_out(s_so), .data_out_q(s_dq), .state_out_q(s_sq)
  );
  ve_lfsr #(
    .LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"), .LFSR_FEED_FORWARD(1),
    .REVERSE(1), .DATA_WIDTH(5), .STYLE("REDUCTION")
  ) u_dscr (
    .clk(clk), .rst_n(rst_n), .data_in(d_di), .state_in(d_si), .data_out(d_do),
    .state_out(d_so), .data_out_q(d_dq), .state_out_q(d_sq)
  );
  ve_lfsr #(
    .LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG("GALOIS"), .LFSR_FEED_FORWARD(1),
    .DATA_WIDTH(4)
  ) u_gal_ff (
    .clk(clk), .rst_n(rst_n), .data_in(g_di), .state_in(g_si), .data_out(g_do),
    .state_out(g_so), .data_out_q(g_dq), .state_out_q(g_sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. Galois forms are treated as polynomial arithmetic modulo
  // G = x^w + poly; Fibonacci forms as a linear recurrence over the bit history.
  task automatic ref_eval(input bit galois, input bit ff, input bit rev, input int w,
                          input int dw, input logic [255:0] poly, input logic [255:0] st,
                          input logic [255:0] dt, output logic [255:0] so,
                          output logic [255:0] rd);
    logic [511:0] s, d, rem, g, o;
    bit           h[$];
    bit           fb;
    int           n;
    s = '0; d = '0; o = '0;
    for (int i = 0; i < w; i++) s[i] = rev ? st[w-1-i] : st[i];
    for (int i = 0; i < dw; i++) d[i] = rev ? dt[dw-1-i] : dt[i];
    g = '0;
    for (int i = 0; i < w; i++) g[i] = poly[i];
    g[w] = 1'b1;
    if (galois && !ff) begin
      // Remainder of (S*x^dw + M*x^w) / G; the quotient bits are the output bits.
      rem = (s << dw) ^ (d << w);
      for (int deg = w + dw - 1; deg >= w; deg--) begin
        if (rem[deg]) begin
          rem = rem ^ (g << (deg - w));
          o[deg-w] = 1'b1;
        end
      end
      s = rem;
    end else if (galois) begin
      // S <- (S*x + d) mod G, output = leading coefficient ^ d.
      for (int j = dw - 1; j >= 0; j--) begin
        o[j] = s[w-1] ^ d[j];
        s = s << 1;
        s[0] = d[j];
        if (s[w]) s = s ^ g;
      end
    end else begin
      for (int i = w - 1; i >= 0; i--) h.push_back(s[i]);
      for (int j = dw - 1; j >= 0; j--) begin
        n  = h.size();
        fb = h[n-w];
        for (int k = 1; k < w; k++) if (poly[k]) fb = fb ^ h[n-k];
        o[j] = fb ^ d[j];
        h.push_back(ff ? d[j] : o[j]);
      end
      n = h.size();
      s = '0;
      for (int i = 0; i < w; i++) s[i] = h[n-1-i];
    end
    so = '0; rd = '0;
    for (int i = 0; i < w; i++) so[i] = rev ? s[w-1-i] : s[i];
    for (int i = 0; i < dw; i++) rd[i] = rev ? o[dw-1-i] : o[i];
  endtask

  task automatic test_reset();
    logic [255:0] rs, rd;
    rst_n = 1'b0;
    p_si = '1; p_di = 8'hA5;
    c_si = $urandom(); c_di = 8'($urandom());
    s_si = 7'($urandom()); s_di = 5'($urandom());
    d_si = 7'($urandom()); d_di = 5'($urandom());
    g_si = 16'($urandom()); g_di = 4'($urandom());
    #1;
    checks++;
    if ({p_sq, p_dq} !== '0) begin
      errors++;
      $display("FAIL reset_prbs_q: got %h/%h, expected 0/0", p_sq, p_dq);
    end
    checks++;
    if ({p_sq_l, p_dq_l, c_sq[0], c_dq[0], c_sq[1], c_dq[1], c_sq[2], c_dq[2],
         s_sq, s_dq, d_sq, d_dq, g_sq, g_dq} !== '0) begin
      errors++;
      $display("FAIL reset_all_q: some registered output nonzero, expected all 0");
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({p_sq, p_dq} !== '0) begin
      errors++;
      $display("FAIL reset_held: got %h/%h after clock edges, expected 0/0", p_sq, p_dq);
    end
    ref_eval(0, 0, 0, 31, 8, PrbsPoly, 256'(p_si), 256'(p_di), rs, rd);
    checks++;
    if (p_so !== rs[30:0] || p_do !== rd[7:0]) begin
      errors++;
      $display("FAIL reset_comb: got %h/%h, expected %h/%h", p_so, p_do, rs[30:0], rd[7:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_crc_vectors();
    logic [255:0] rs, rd;
    logic [31:0]  st;
    c_si = 32'hFFFFFFFF; c_di = 8'h00;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (c_so[i] !== 32'h2DFD1072) begin
        errors++;
        $display("FAIL crc_zero_byte[%0d]: got %h, expected 2dfd1072", i, c_so[i]);
      end
    end
    st = 32'hFFFFFFFF;
    for (int b = 0; b < 9; b++) begin
      c_si = st;
      c_di = 8'h31 + 8'(b);
      #1;
      ref_eval(1, 0, 1, 32, 8, CrcPoly, 256'(c_si), 256'(c_di), rs, rd);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (c_so[i] !== rs[31:0] || c_do[i] !== rd[7:0]) begin
          errors++;
          $display("FAIL crc_chain[%0d] style %0d: got %h/%h, expected %h/%h", b, i,
                   c_so[i], c_do[i], rs[31:0], rd[7:0]);
        end
      end
      st = c_so[0];
    end
    checks++;
    if (st !== 32'h340BC6D9) begin
      errors++;
      $display("FAIL crc_check_state: got %h, expected 340bc6d9", st);
    end
    checks++;
    if (~st !== 32'hCBF43926) begin
      errors++;
      $display("FAIL crc_check_fcs: got %h, expected cbf43926", ~st);
    end
  endtask

  task automatic test_prbs_sequence();
    logic [255:0] rs, rd;
    logic [30:0]  st;
    st = '1;
    for (int n = 0; n < 1000; n++) begin
      p_si = st; p_di = 8'h00;
      #1;
      ref_eval(0, 0, 0, 31, 8, PrbsPoly, 256'(st), 256'(0), rs, rd);
      checks++;
      if (p_so !== rs[30:0] || p_do !== rd[7:0] || p_so_l !== rs[30:0] ||
          p_do_l !== rd[7:0]) begin
        errors++;
        $display("FAIL prbs_step[%0d]: got %h/%h loop %h/%h, expected %h/%h", n, p_so,
                 p_do, p_so_l, p_do_l, rs[30:0], rd[7:0]);
      end
      st = rs[30:0];
    end
  endtask

  task automatic test_styles();
    logic [255:0] rs, rd, cs, cd;
    for (int n = 0; n < 10000; n++) begin
      p_si = 31'($urandom()); p_di = 8'($urandom());
      c_si = $urandom();      c_di = 8'($urandom());
      #1;
      ref_eval(0, 0, 0, 31, 8, PrbsPoly, 256'(p_si), 256'(p_di), rs, rd);
      ref_eval(1, 0, 1, 32, 8, CrcPoly, 256'(c_si), 256'(c_di), cs, cd);
      checks++;
      if (p_so !== rs[30:0] || p_do !== rd[7:0]) begin
        errors++;
        $display("FAIL style_prbs_auto[%0d]: got %h/%h, expected %h/%h", n, p_so, p_do,
                 rs[30:0], rd[7:0]);
      end
      checks++;
      if (p_so_l !== rs[30:0] || p_do_l !== rd[7:0]) begin
        errors++;
        $display("FAIL style_prbs_loop[%0d]: got %h/%h, expected %h/%h", n, p_so_l,
                 p_do_l, rs[30:0], rd[7:0]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (c_so[i] !== cs[31:0] || c_do[i] !== cd[7:0]) begin
          errors++;
          $display("FAIL style_crc[%0d] style %0d: got %h/%h, expected %h/%h", n, i,
                   c_so[i], c_do[i], cs[31:0], cd[7:0]);
        end
      end
    end
  endtask

  task automatic test_scrambler();
    logic [255:0] rs, rd;
    logic [4:0]   data;
    logic [6:0]   seed;
    // Phase 0: both seeded alike. Phase 1: descrambler seed differs and must self-sync
    // once a full state width of scrambled bits has passed (two evaluations).
    for (int phase = 0; phase < 2; phase++) begin
      seed = 7'($urandom());
      s_si = seed;
      d_si = (phase == 0) ? seed : ~seed;
      for (int n = 0; n < 300; n++) begin
        data = 5'($urandom());
        s_di = data;
        #1;
        ref_eval(0, 0, 1, 7, 5, ScrPoly, 256'(s_si), 256'(data), rs, rd);
        checks++;
        if (s_so !== rs[6:0] || s_do !== rd[4:0]) begin
          errors++;
          $display("FAIL scrambler[%0d.%0d]: got %h/%h, expected %h/%h", phase, n, s_so,
                   s_do, rs[6:0], rd[4:0]);
        end
        d_di = s_do;
        #1;
        if (phase == 0 || n >= 2) begin
          checks++;
          if (d_do !== data) begin
            errors++;
            $display("FAIL descrambler[%0d.%0d]: got %h, expected %h", phase, n, d_do, data);
          end
        end
        s_si = s_so;
        d_si = d_so;
      end
    end
  endtask

  task automatic test_galois_ff();
    logic [255:0] rs, rd;
    for (int n = 0; n < 500; n++) begin
      g_si = 16'($urandom()); g_di = 4'($urandom());
      #1;
      ref_eval(1, 1, 0, 16, 4, GalPoly, 256'(g_si), 256'(g_di), rs, rd);
      checks++;
      if (g_so !== rs[15:0] || g_do !== rd[3:0]) begin
        errors++;
        $display("FAIL galois_ff[%0d]: got %h/%h, expected %h/%h", n, g_so, g_do,
                 rs[15:0], rd[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] rs, rd;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      p_si = 31'($urandom()); p_di = 8'($urandom());
      ref_eval(0, 0, 0, 31, 8, PrbsPoly, 256'(p_si), 256'(p_di), rs, rd);
      @(posedge clk);
      #1;
      checks++;
      if (p_sq !== rs[30:0] || p_dq !== rd[7:0]) begin
        errors++;
        $display("FAIL registered[%0d]: got %h/%h, expected %h/%h", n, p_sq, p_dq,
                 rs[30:0], rd[7:0]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [255:0] rs, rd;
    @(negedge clk);
    p_si = 31'($urandom()) | 31'h1; p_di = 8'hFF;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({p_sq, p_dq} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got %h/%h, expected 0/0", p_sq, p_dq);
    end
    p_si = 31'($urandom()); p_di = 8'($urandom());
    @(posedge clk);
    #1;
    checks++;
    if ({p_sq, p_dq} !== '0) begin
      errors++;
      $display("FAIL midreset_hold: got %h/%h, expected 0/0", p_sq, p_dq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    p_si = 31'($urandom()); p_di = 8'($urandom());
    ref_eval(0, 0, 0, 31, 8, PrbsPoly, 256'(p_si), 256'(p_di), rs, rd);
    @(posedge clk);
    #1;
    checks++;
    if (p_sq !== rs[30:0] || p_dq !== rd[7:0]) begin
      errors++;
      $display("FAIL midreset_release: got %h/%h, expected %h/%h", p_sq, p_dq,
               rs[30:0], rd[7:0]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    p_si = '0; p_di = '0; c_si = '0; c_di = '0;
    s_si = '0; s_di = '0; d_si = '0; d_di = '0; g_si = '0; g_di = '0;
    test_reset();
    test_crc_vectors();
    test_prbs_sequence();
    test_styles();
    test_scrambler();
    test_galois_ff();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
